// File: rtl/distribute_1xn_mcast_pipe_pkg.sv
// ---------------------------------------------------------------------------
// distribute_pkg
// Shared constants for the 1xN multicast distributor:
//   NUM_OUT_MIN/NUM_OUT_MAX : legal range for the branch count
//   CMD_NONE                : destination mask value meaning "no branch"
//   dist_state_e            : IDLE (nothing pending) / BUSY (something pending)
//   bcast_mask()            : full-broadcast mask for a given branch count
// ---------------------------------------------------------------------------
package distribute_pkg;

    localparam int NUM_OUT_MIN = 2;
    localparam int NUM_OUT_MAX = 16;
    localparam int CMD_NONE    = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dist_state_e;

    // Low n bits set; callers slice down to their own branch count.
    function automatic logic [NUM_OUT_MAX-1:0] bcast_mask(input int n);
        logic [NUM_OUT_MAX-1:0] m;
        m = {NUM_OUT_MAX{1'b0}};
        for (int k = 0; k < NUM_OUT_MAX; k++) begin
            m[k] = (k < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/distribute_1xn_mcast_pipe_if.sv
// ---------------------------------------------------------------------------
// distribute_1xn_mcast_pipe_if
// Handshake/bus bundle of the distributor. Signal names are from the
// distributor's point of view (i_* flow into it, o_* flow out of it).
//   i_valid, i_data_bus, i_cmd, i_en : upstream transaction + switch enable
//   o_ready                          : upstream acceptance
//   o_valid, o_data_bus              : per-branch valid / packed lane data
//   i_ready                          : per-branch downstream ready
// Modports: slave = the distributor, master = whatever drives it.
// ---------------------------------------------------------------------------
interface distribute_1xn_mcast_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4
);
    logic                          i_valid;
    logic [DATA_WIDTH-1:0]         i_data_bus;
    logic [NUM_OUT-1:0]            i_cmd;
    logic                          i_en;
    logic                          o_ready;
    logic [NUM_OUT-1:0]            o_valid;
    logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus;
    logic [NUM_OUT-1:0]            i_ready;

    modport slave (
        input  i_valid, i_data_bus, i_cmd, i_en, i_ready,
        output o_ready, o_valid, o_data_bus
    );

    modport master (
        output i_valid, i_data_bus, i_cmd, i_en, i_ready,
        input  o_ready, o_valid, o_data_bus
    );
endinterface

// File: rtl/distribute_1xn_mcast_pipe_lane_ctrl.sv
// ---------------------------------------------------------------------------
// distribute_lane_ctrl
// One output branch: owns the branch's pending bit and masks the shared
// held data so an idle lane shows all zeros.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : a transaction is accepted this cycle
//   i_sel     : this branch's bit of the accepted destination mask
//   i_ready   : downstream ready for this branch
//   i_data    : held payload shared by all branches
//   o_valid   : branch valid (== pending bit)
//   o_data    : held payload when pending, else zeros
// ---------------------------------------------------------------------------
module distribute_lane_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_sel,
    input  logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic r_pend;

    // Pending bit: a new load wins over completing the old delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend <= i_sel;
        end else if (r_pend && i_ready) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

    assign o_valid = r_pend;
    assign o_data  = r_pend ? i_data : {DATA_WIDTH{1'b0}};
endmodule

// File: rtl/distribute_1xn_mcast_pipe.sv
// ---------------------------------------------------------------------------
// distribute_1xn_mcast_pipe
// 1-to-N multicast distributor with a single registered transaction slot.
// An accepted payload is copied to every branch selected by i_cmd; each
// branch completes independently. A new transaction is accepted in the same
// cycle the last outstanding branch completes, so broadcast streams run at
// one transaction per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : distribute_1xn_mcast_pipe_if.slave handshake/data bundle
// Optional (macro DISTRIBUTE_STATS_EN):
//   o_pkt_cnt  : saturating count of accepts with a non-empty mask
//   o_drop_cnt : saturating count of accepts with an empty mask
// ---------------------------------------------------------------------------
module distribute_1xn_mcast_pipe
    import distribute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef DISTRIBUTE_STATS_EN
    output logic [STAT_WIDTH-1:0]         o_pkt_cnt,
    output logic [STAT_WIDTH-1:0]         o_drop_cnt,
`endif
    distribute_1xn_mcast_pipe_if.slave    bus
);
    localparam logic [NUM_OUT_MAX-1:0] BCAST_FULL = bcast_mask(NUM_OUT);
    localparam logic [NUM_OUT-1:0]     BCAST      = BCAST_FULL[NUM_OUT-1:0];

    if ((NUM_OUT < NUM_OUT_MIN) || (NUM_OUT > NUM_OUT_MAX) || (STAT_WIDTH < 1)) begin : g_bad_param
        $error("distribute_1xn_mcast_pipe: illegal NUM_OUT or STAT_WIDTH");
    end

    logic [DATA_WIDTH-1:0]         r_data;
    logic [NUM_OUT-1:0]            w_pend;
    logic [NUM_OUT*DATA_WIDTH-1:0] w_data_bus;
    logic [NUM_OUT-1:0]            w_cmd;
    logic                          w_accept;
    logic                          w_ready;
    dist_state_e                   w_state;

    assign w_cmd    = bus.i_cmd & BCAST;
    assign w_accept = bus.i_valid & bus.i_en & w_ready;

    // State is fully implied by the pending mask.
    always_comb begin
        w_state = ST_IDLE;
        if (|w_pend) begin
            w_state = ST_BUSY;
        end else begin
            w_state = ST_IDLE;
        end
    end

    // Ready when idle, or when every still-pending branch completes now.
    always_comb begin
        w_ready = 1'b0;
        case (w_state)
            ST_IDLE: w_ready = 1'b1;
            ST_BUSY: w_ready = ~|(w_pend & ~bus.i_ready);
            default: w_ready = 1'b0;
        endcase
    end

    // Held payload, shared by all lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_data <= bus.i_data_bus;
        end else begin
            r_data <= r_data;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        distribute_lane_ctrl #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_accept),
            .i_sel   (w_cmd[k]),
            .i_ready (bus.i_ready[k]),
            .i_data  (r_data),
            .o_valid (w_pend[k]),
            .o_data  (w_data_bus[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = w_pend;
    assign bus.o_data_bus = w_data_bus;

`ifdef DISTRIBUTE_STATS_EN
    logic [STAT_WIDTH-1:0] r_pkt_cnt;
    logic [STAT_WIDTH-1:0] r_drop_cnt;
    logic                  w_is_drop;

    assign w_is_drop = (w_cmd == NUM_OUT'(CMD_NONE));

    // Saturating accept counters, split by empty / non-empty mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt  <= {STAT_WIDTH{1'b0}};
            r_drop_cnt <= {STAT_WIDTH{1'b0}};
        end else if (w_accept && !w_is_drop && (r_pkt_cnt != {STAT_WIDTH{1'b1}})) begin
            r_pkt_cnt  <= r_pkt_cnt + STAT_WIDTH'(1);
            r_drop_cnt <= r_drop_cnt;
        end else if (w_accept && w_is_drop && (r_drop_cnt != {STAT_WIDTH{1'b1}})) begin
            r_pkt_cnt  <= r_pkt_cnt;
            r_drop_cnt <= r_drop_cnt + STAT_WIDTH'(1);
        end else begin
            r_pkt_cnt  <= r_pkt_cnt;
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign o_pkt_cnt  = r_pkt_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif
endmodule

// File: doc/distribute_1xn_mcast_pipe.md
DISTRIBUTE_1XN_MCAST_PIPE -- requirements
Module: distribute_1xn_mcast_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter NUM_OUT, default 4, output branch count; legal range is 2..16.
REQ-003 SHALL have parameter STAT_WIDTH, default 16, statistics counter width; used only under DISTRIBUTE_STATS_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1 bit: input transaction valid.
REQ-007 SHALL have port i_data_bus, input, DATA_WIDTH: input payload.
REQ-008 SHALL have port i_cmd, input, NUM_OUT: destination bitmask; bit k selects branch k; all-ones is full broadcast.
REQ-009 SHALL have port i_en, input, 1 bit: switch enable; gates input acceptance only.
REQ-010 SHALL have port o_ready, output, 1 bit: input accepted this cycle when i_valid & i_en & o_ready.
REQ-011 SHALL have port o_valid, output, NUM_OUT: per-branch valid.
REQ-012 SHALL have port o_data_bus, output, NUM_OUT*DATA_WIDTH: branch k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port i_ready, input, NUM_OUT: per-branch downstream ready.

Function
REQ-014 SHALL hold one registered transaction: a DATA_WIDTH data register plus a NUM_OUT pending mask.
REQ-015 SHALL be in IDLE when pending==0 and in BUSY otherwise; no other state exists.
REQ-016 SHALL drive o_valid[k] = pending[k] and lane k data = held data if pending[k], else all zeros (dummy data).
REQ-017 SHALL complete branch k (clear pending[k]) on any cycle where o_valid[k] & i_ready[k]; branches complete independently and in any order.
REQ-018 SHALL drive o_ready = 1 when pending & ~i_ready == 0, i.e. idle, or every remaining branch completes this cycle (combinational path i_ready->o_ready).
REQ-019 SHALL, on accept, load data and pending <= i_cmd at the next edge, giving 1-cycle latency from accept to o_valid; back-to-back accepts sustain one transaction per cycle.
REQ-020 SHALL, on accept with i_cmd==0, consume and discard the input, leaving pending=0 and asserting no o_valid.
REQ-021 SHALL, with i_en=0, accept nothing while an outstanding transaction continues to drain normally.
REQ-022 SHALL let a simultaneous last-branch completion and new accept load the new transaction; the new load takes precedence over clearing.
REQ-023 SHALL never duplicate a delivery: once pending[k] clears, branch k stays invalid until the next load.
REQ-024 SHALL not let o_valid/o_data depend combinationally on i_valid, i_cmd or i_data_bus.

Reset
REQ-025 SHALL, while rst=1 at an edge, clear pending, data and all counters; after reset o_valid=0, o_data_bus=0, o_ready=1.
REQ-026 SHALL, on reset mid-transaction, drop partially delivered branches with no further o_valid.

Configuration
REQ-027 SHALL, with DISTRIBUTE_STATS_EN defined, add outputs o_pkt_cnt[STAT_WIDTH] (accepts with i_cmd!=0) and o_drop_cnt[STAT_WIDTH] (accepts with i_cmd==0), each saturating at all-ones.
REQ-028 SHALL, without DISTRIBUTE_STATS_EN, omit these ports and counters; behaviour is otherwise identical.

Structure
REQ-029 SHALL place command-encoding constants (CMD_NONE=0, broadcast mask helper) and the NUM_OUT legality bound in package distribute_pkg.
REQ-030 SHALL implement per-branch pending bit, valid and data masking in sub-module distribute_lane_ctrl, instantiated NUM_OUT times by generate.

Verification
REQ-031 SHALL verify unicast (NUM_OUT=4, DATA_WIDTH=32): i_cmd=4'b0100, data=32'hDEADBEEF, all i_ready=1 -> next cycle o_valid=4'b0100, lane2=DEADBEEF, other lanes 0, o_ready=1.
REQ-032 SHALL verify multicast with stall: i_cmd=4'b1011, i_ready=4'b0001 then 4'b1010 -> lane0 completes cycle 1, lanes 1/3 cycle 2, o_ready=0 in cycle 1 and 1 in cycle 2.
REQ-033 SHALL verify streaming: 8 consecutive broadcasts 4'b1111 with i_ready=4'b1111 -> 8 outputs on 8 consecutive cycles, o_ready held 1.
REQ-034 SHALL verify drop/enable: i_cmd=0 accept -> no o_valid, o_drop_cnt+1 (stats build); i_en=0 with i_valid=1 -> no load, pending unchanged.
REQ-035 SHALL verify reset mid-operation: pending=4'b0110, assert rst one cycle -> o_valid=0, o_data_bus=0, o_ready=1 next cycle.
REQ-036 SHALL verify saturation: STAT_WIDTH=4, 20 valid accepts -> o_pkt_cnt holds 4'hF.
